// File: rtl/memory_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_game_pkg
// Description : Shared constants for the memory game: coordinate width,
//               default start button geometry (also used by the renderer),
//               default debounce length and start button FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_game_pkg;

    // Pointer coordinate width delivered by the mouse controller
    localparam int c_coord_w = 12;

    // Default on-screen start button rectangle, pixels
    localparam int c_start_btn_x = 412;
    localparam int c_start_btn_y = 334;
    localparam int c_start_btn_w = 200;
    localparam int c_start_btn_h = 100;

    // Default number of stable cycles before a button level change is accepted
    localparam int c_debounce_cycles = 65000;

    // Start button click FSM encodings
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] ARMED        = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser followed by a counter debouncer. The
//               debounced level flips only after the synchronised input has
//               disagreed with it for DEBOUNCE_CYCLES consecutive cycles plus
//               the flip cycle itself. Shared with the board pushbuttons.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import memory_game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing cycles; flip the level once the run is long enough
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + c_cnt_w'(1);
        end
    end

    assign btn_level = r_level;

endmodule
`default_nettype wire

// File: rtl/start_button_ctl.sv
`default_nettype none
// ============================================================================
// Module      : start_button_ctl
// Description : Turns raw mouse activity into a one-cycle start button click.
//               A click needs both the debounced press and the debounced
//               release to land inside the button rectangle while the menu is
//               displayed (enable high). Optional hover output is built when
//               the macro START_BTN_HOVER_EN is defined; otherwise it is tied
//               low and its register is not generated.
// Revision    : 1.0 - initial release
// ============================================================================
module start_button_ctl
    import memory_game_pkg::*;
#(
    parameter int BTN_X           = c_start_btn_x,
    parameter int BTN_Y           = c_start_btn_y,
    parameter int BTN_W           = c_start_btn_w,
    parameter int BTN_H           = c_start_btn_h,
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_coord_w-1:0] mouse_xpos,
    input  logic [c_coord_w-1:0] mouse_ypos,
    input  logic                 mouse_left,
    input  logic                 enable,
    output logic                 start_button_pressed,
    output logic                 hover
);

    // One extra bit so that edge + size never wraps
    localparam int c_pos_w = c_coord_w + 1;

    localparam logic [c_pos_w-1:0] c_x_lo = c_pos_w'(BTN_X);
    localparam logic [c_pos_w-1:0] c_x_hi = c_pos_w'(BTN_X + BTN_W);
    localparam logic [c_pos_w-1:0] c_y_lo = c_pos_w'(BTN_Y);
    localparam logic [c_pos_w-1:0] c_y_hi = c_pos_w'(BTN_Y + BTN_H);

    logic               w_btn_level;
    logic               r_level_d;
    logic               w_rise;
    logic               w_fall;
    logic               r_enable_d;
    logic               w_enable_rise;
    logic [c_pos_w-1:0] w_x;
    logic [c_pos_w-1:0] w_y;
    logic               w_inside_next;
    logic               r_inside;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_pulse_next;
    logic               r_pulse;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (mouse_left),
        .btn_level (w_btn_level)
    );

    assign w_x           = {1'b0, mouse_xpos};
    assign w_y           = {1'b0, mouse_ypos};
    assign w_inside_next = (w_x >= c_x_lo) && (w_x < c_x_hi) &&
                           (w_y >= c_y_lo) && (w_y < c_y_hi);

    // Delayed copies used for edge detection, plus the registered hit test
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_d  <= 1'b0;
            r_enable_d <= 1'b0;
            r_inside   <= 1'b0;
        end else begin
            r_level_d  <= w_btn_level;
            r_enable_d <= enable;
            r_inside   <= w_inside_next;
        end
    end

    assign w_rise        = w_btn_level  & ~r_level_d;
    assign w_fall        = ~w_btn_level & r_level_d;
    assign w_enable_rise = enable & ~r_enable_d;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: menu hidden wins, then a button already held when the menu appears
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = IDLE;
        end else if (w_enable_rise && w_btn_level) begin
            w_state_next = WAIT_RELEASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_state_next = r_inside ? ARMED : WAIT_RELEASE;
                    end
                end
                ARMED: begin
                    if (w_fall) begin
                        w_state_next = IDLE;
                    end
                end
                WAIT_RELEASE: begin
                    if (w_fall) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // FSM output: click when an armed press is released inside the rectangle
    always_comb begin
        w_pulse_next = 1'b0;
        if (enable && (r_state == ARMED) && w_fall && r_inside) begin
            w_pulse_next = 1'b1;
        end
    end

    // Register the click pulse so the output is glitch free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_pulse_next;
        end
    end

    assign start_button_pressed = r_pulse;

`ifdef START_BTN_HOVER_EN
    logic r_hover;

    // Pointer over the button while the menu is shown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hover <= 1'b0;
        end else begin
            r_hover <= r_inside && enable;
        end
    end

    assign hover = r_hover;
`else
    assign hover = 1'b0;
`endif

endmodule
`default_nettype wire
